// File: rtl/cdb_arb_pkg.sv
// cdb_arb_pkg: shared constants for the CDB arbiter slice.
//   SRC_RS / SRC_LSB     : encoding of CDB_src and of the last-grant record
//   ROB_WIDTH_DEF        : default width of an RoB index
//   ADDR_WIDTH_DEF       : default width of next_pc
//   DATA_WIDTH           : width of a result value
//   PAYLOAD_WIDTH_DEF    : queue entry width {RoB index, value, next_pc}
//   payload_width()      : queue entry width for non-default parameters
package cdb_arb_pkg;

    localparam logic SRC_RS  = 1'b0;
    localparam logic SRC_LSB = 1'b1;

    localparam int ROB_WIDTH_DEF     = 4;
    localparam int ADDR_WIDTH_DEF    = 32;
    localparam int DATA_WIDTH        = 32;
    localparam int PAYLOAD_WIDTH_DEF = ROB_WIDTH_DEF + DATA_WIDTH + ADDR_WIDTH_DEF;

    function automatic int payload_width(input int rob_w, input int addr_w);
        return rob_w + DATA_WIDTH + addr_w;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer handshakes and CDB broadcast of the arbiter.
//   RSARB_*   : RS/ALU result offered to the arbiter (en, RoB index, value, next_pc)
//   ARBRS_ready
//   LSBARB_*  : load/store completion offered to the arbiter (en, RoB index, value)
//   ARBLSB_ready
//   CDB_*     : registered broadcast (en, RoB index, value, next_pc, src)
// Handshake: a result transfers at a rising edge where xx_en and ARBxx_ready
// are both 1 (with the arbiter enabled and not flushing). ready depends only
// on registered queue occupancy, never on en; a producer must not raise en
// while ready is 0. CDB_en is a one-cycle pulse with no back-pressure.
// modport slave  : the arbiter side
// modport master : the producers/consumers side
interface cdb_arbiter_if
    import cdb_arb_pkg::*;
#(
    parameter int RoB_WIDTH  = ROB_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  RSARB_en;
    logic [RoB_WIDTH-1:0]  RSARB_RoB_index;
    logic [DATA_WIDTH-1:0] RSARB_value;
    logic [ADDR_WIDTH-1:0] RSARB_next_pc;
    logic                  ARBRS_ready;

    logic                  LSBARB_en;
    logic [RoB_WIDTH-1:0]  LSBARB_RoB_index;
    logic [DATA_WIDTH-1:0] LSBARB_value;
    logic                  ARBLSB_ready;

    logic                  CDB_en;
    logic [RoB_WIDTH-1:0]  CDB_RoB_index;
    logic [DATA_WIDTH-1:0] CDB_value;
    logic [ADDR_WIDTH-1:0] CDB_next_pc;
    logic                  CDB_src;

    modport slave (
        input  RSARB_en, RSARB_RoB_index, RSARB_value, RSARB_next_pc,
        input  LSBARB_en, LSBARB_RoB_index, LSBARB_value,
        output ARBRS_ready, ARBLSB_ready,
        output CDB_en, CDB_RoB_index, CDB_value, CDB_next_pc, CDB_src
    );

    modport master (
        output RSARB_en, RSARB_RoB_index, RSARB_value, RSARB_next_pc,
        output LSBARB_en, LSBARB_RoB_index, LSBARB_value,
        input  ARBRS_ready, ARBLSB_ready,
        input  CDB_en, CDB_RoB_index, CDB_value, CDB_next_pc, CDB_src
    );

endinterface

// File: rtl/cdb_arb_fifo.sv
// cdb_arb_fifo: small private result queue for one CDB producer.
//   Sys_clk, Sys_rst_n : clock, asynchronous active-low reset
//   push, din          : write din at the tail (ignored when full)
//   pop                : drop the head (ignored when empty)
//   flush              : clear the queue; wins over push and pop
//   hold               : freeze all state, including flush
//   head               : current head entry (stale when empty)
//   count, full, empty : occupancy
module cdb_arb_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 2,
    parameter int PTR_WIDTH = 1
) (
    input  logic                 Sys_clk,
    input  logic                 Sys_rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic                 hold,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     head,
    output logic [PTR_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty
);
    localparam int               CW      = PTR_WIDTH + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full  && !hold && !flush;
    assign do_pop  = pop  && !empty && !hold && !flush;

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush && !hold) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge Sys_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin share of the CDB write-back path between the
// RS/ALU producer and the load-store buffer.
//   Sys_clk, Sys_rst_n  : clock, asynchronous active-low reset
//   Sys_rdy             : global enable; 0 holds all state, no broadcast
//   RoBARB_pre_judge    : 0 flushes both queues (mispredict)
//   bus (slave)         : producer handshakes and registered CDB broadcast
// Optional macro CDB_ARB_STATS_EN adds stat_rs_grants, stat_lsb_grants and
// stat_conflicts (32-bit wrapping counters, cleared only by reset).
module cdb_arbiter
    import cdb_arb_pkg::*;
#(
    parameter int RoB_WIDTH      = ROB_WIDTH_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int FIFO_DEPTH     = 2,
    parameter int FIFO_PTR_WIDTH = 1
) (
    input  logic          Sys_clk,
    input  logic          Sys_rst_n,
    input  logic          Sys_rdy,
    input  logic          RoBARB_pre_judge,
    cdb_arbiter_if.slave  bus
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [31:0]   stat_rs_grants,
    output logic [31:0]   stat_lsb_grants,
    output logic [31:0]   stat_conflicts
`endif
);
    localparam int            PW      = payload_width(RoB_WIDTH, ADDR_WIDTH);
    localparam int            CW      = FIFO_PTR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [PW-1:0] rs_din, lsb_din, rs_head, lsb_head, sel_head;
    logic [CW-1:0] rs_count, lsb_count;
    logic          rs_full, rs_empty, lsb_full, lsb_empty;
    logic          active, flush, grant_rs, grant_lsb, both_pending;
    logic          last_grant;

    logic                  cdb_en_q;
    logic [RoB_WIDTH-1:0]  cdb_idx_q;
    logic [DATA_WIDTH-1:0] cdb_value_q;
    logic [ADDR_WIDTH-1:0] cdb_pc_q;
    logic                  cdb_src_q;

    assign active = Sys_rdy && RoBARB_pre_judge;
    assign flush  = Sys_rdy && !RoBARB_pre_judge;

    // LSB results carry no next_pc; a zero field is broadcast for them.
    assign rs_din  = {bus.RSARB_RoB_index, bus.RSARB_value, bus.RSARB_next_pc};
    assign lsb_din = {bus.LSBARB_RoB_index, bus.LSBARB_value, {ADDR_WIDTH{1'b0}}};

    // Round-robin on the registered heads: a tie goes to the queue that did
    // not win last time, otherwise the only non-empty queue wins.
    assign both_pending = !rs_empty && !lsb_empty;
    assign grant_rs     = !rs_empty && (lsb_empty || last_grant == SRC_LSB);
    assign grant_lsb    = !lsb_empty && !grant_rs;
    assign sel_head     = grant_rs ? rs_head : lsb_head;

    cdb_arb_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH), .PTR_WIDTH(FIFO_PTR_WIDTH)) u_rs_fifo (
        .Sys_clk   (Sys_clk),
        .Sys_rst_n (Sys_rst_n),
        .push      (bus.RSARB_en && !rs_full),
        .pop       (active && grant_rs),
        .flush     (flush),
        .hold      (!Sys_rdy),
        .din       (rs_din),
        .head      (rs_head),
        .count     (rs_count),
        .full      (rs_full),
        .empty     (rs_empty)
    );

    cdb_arb_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH), .PTR_WIDTH(FIFO_PTR_WIDTH)) u_lsb_fifo (
        .Sys_clk   (Sys_clk),
        .Sys_rst_n (Sys_rst_n),
        .push      (bus.LSBARB_en && !lsb_full),
        .pop       (active && grant_lsb),
        .flush     (flush),
        .hold      (!Sys_rdy),
        .din       (lsb_din),
        .head      (lsb_head),
        .count     (lsb_count),
        .full      (lsb_full),
        .empty     (lsb_empty)
    );

    // Ready looks only at registered occupancy, so there is no path from en
    // or from a same-cycle pop.
    assign bus.ARBRS_ready  = (rs_count  < DEPTH_C);
    assign bus.ARBLSB_ready = (lsb_count < DEPTH_C);

    // Payload registers only load on a grant, so stale values stay visible
    // while CDB_en is low.
    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            cdb_en_q    <= 1'b0;
            cdb_idx_q   <= '0;
            cdb_value_q <= '0;
            cdb_pc_q    <= '0;
            cdb_src_q   <= SRC_RS;
            last_grant  <= SRC_LSB;
        end else if (!Sys_rdy) begin
            cdb_en_q <= 1'b0;
        end else if (!RoBARB_pre_judge) begin
            cdb_en_q   <= 1'b0;
            last_grant <= SRC_LSB;
        end else if (grant_rs || grant_lsb) begin
            cdb_en_q                            <= 1'b1;
            {cdb_idx_q, cdb_value_q, cdb_pc_q}  <= sel_head;
            cdb_src_q                           <= grant_rs ? SRC_RS : SRC_LSB;
            last_grant                          <= grant_rs ? SRC_RS : SRC_LSB;
        end else begin
            cdb_en_q <= 1'b0;
        end
    end

    assign bus.CDB_en        = cdb_en_q;
    assign bus.CDB_RoB_index = cdb_idx_q;
    assign bus.CDB_value     = cdb_value_q;
    assign bus.CDB_next_pc   = cdb_pc_q;
    assign bus.CDB_src       = cdb_src_q;

`ifdef CDB_ARB_STATS_EN
    // Flush does not clear the counters; only reset does.
    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            stat_rs_grants  <= '0;
            stat_lsb_grants <= '0;
            stat_conflicts  <= '0;
        end else if (active && (grant_rs || grant_lsb)) begin
            if (grant_rs) stat_rs_grants  <= stat_rs_grants + 32'd1;
            else          stat_lsb_grants <= stat_lsb_grants + 32'd1;
            if (both_pending) stat_conflicts <= stat_conflicts + 32'd1;
        end
    end
`else
    logic both_pending_unused;
    assign both_pending_unused = both_pending;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized and directed bench for cdb_arbiter with a
// queue-based reference model checked every cycle on the falling edge.
// Honours CDB_ARB_STATS_EN when defined.
module tb_cdb_arbiter;
    import cdb_arb_pkg::*;

    localparam int RW    = 4;
    localparam int AW    = 32;
    localparam int DEPTH = 2;
    localparam int PW    = RW + 32 + AW;

    // ---------------- clock / reset ----------------
    logic Sys_clk   = 1'b0;
    logic Sys_rst_n = 1'b0;
    logic Sys_rdy   = 1'b1;
    logic pre_judge = 1'b1;

    always #5 Sys_clk = ~Sys_clk;

    cdb_arbiter_if #(.RoB_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

`ifdef CDB_ARB_STATS_EN
    logic [31:0] stat_rs, stat_lsb, stat_conf;
`endif

    cdb_arbiter #(.RoB_WIDTH(RW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .FIFO_PTR_WIDTH(1)) dut (
        .Sys_clk          (Sys_clk),
        .Sys_rst_n        (Sys_rst_n),
        .Sys_rdy          (Sys_rdy),
        .RoBARB_pre_judge (pre_judge),
        .bus              (bus)
`ifdef CDB_ARB_STATS_EN
        ,
        .stat_rs_grants   (stat_rs),
        .stat_lsb_grants  (stat_lsb),
        .stat_conflicts   (stat_conf)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [PW-1:0] rs_exp_q[$];
    logic [PW-1:0] lsb_exp_q[$];
    logic          m_en   = 1'b0;
    logic [RW-1:0] m_idx  = '0;
    logic [31:0]   m_val  = '0;
    logic [AW-1:0] m_pc   = '0;
    logic          m_src  = 1'b0;
    logic          m_last = 1'b1;
    logic [31:0]   m_rs_g = '0, m_lsb_g = '0, m_conf = '0;
    logic          m_pick, m_any, m_rs_acc, m_lsb_acc;
    logic [PW-1:0] m_w;

    always @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            rs_exp_q.delete();
            lsb_exp_q.delete();
            m_en = 1'b0; m_idx = '0; m_val = '0; m_pc = '0; m_src = 1'b0;
            m_last = 1'b1; m_rs_g = '0; m_lsb_g = '0; m_conf = '0;
        end else if (!Sys_rdy) begin
            m_en = 1'b0;
        end else if (!pre_judge) begin
            rs_exp_q.delete();
            lsb_exp_q.delete();
            m_en = 1'b0;
            m_last = 1'b1;
        end else begin
            m_rs_acc  = bus.RSARB_en  && (rs_exp_q.size()  < DEPTH);
            m_lsb_acc = bus.LSBARB_en && (lsb_exp_q.size() < DEPTH);
            m_any = 1'b1;
            if (rs_exp_q.size() > 0 && lsb_exp_q.size() > 0) begin
                m_pick = ~m_last;
                m_conf = m_conf + 1;
            end else if (rs_exp_q.size() > 0) m_pick = 1'b0;
            else if (lsb_exp_q.size() > 0)    m_pick = 1'b1;
            else m_any = 1'b0;
            if (m_any) begin
                if (m_pick) begin m_w = lsb_exp_q.pop_front(); m_lsb_g = m_lsb_g + 1; end
                else        begin m_w = rs_exp_q.pop_front();  m_rs_g  = m_rs_g + 1;  end
                {m_idx, m_val, m_pc} = m_w;
                m_en = 1'b1; m_src = m_pick; m_last = m_pick;
            end else begin
                m_en = 1'b0;
            end
            if (m_rs_acc)  rs_exp_q.push_back({bus.RSARB_RoB_index, bus.RSARB_value, bus.RSARB_next_pc});
            if (m_lsb_acc) lsb_exp_q.push_back({bus.LSBARB_RoB_index, bus.LSBARB_value, {AW{1'b0}}});
        end
    end

    // ---------------- compare process + broadcast log ----------------
    logic [4:0] cdb_log[$];

    always @(negedge Sys_clk) begin
        check("cdb_en",    bus.CDB_en,        m_en);
        check("cdb_idx",   bus.CDB_RoB_index, m_idx);
        check("cdb_value", bus.CDB_value,     m_val);
        check("cdb_pc",    bus.CDB_next_pc,   m_pc);
        check("cdb_src",   bus.CDB_src,       m_src);
        check("rs_ready",  bus.ARBRS_ready,   rs_exp_q.size()  < DEPTH);
        check("lsb_ready", bus.ARBLSB_ready,  lsb_exp_q.size() < DEPTH);
`ifdef CDB_ARB_STATS_EN
        check("stat_rs",   stat_rs,   m_rs_g);
        check("stat_lsb",  stat_lsb,  m_lsb_g);
        check("stat_conf", stat_conf, m_conf);
`endif
        if (bus.CDB_en) cdb_log.push_back({bus.CDB_src, bus.CDB_RoB_index});
    end

    // ---------------- driver ----------------
    // Each producer offers the front of its pending list whenever ready is 1.
    logic [PW-1:0] rs_pend[$];
    logic [PW-1:0] lsb_pend[$];
    logic [PW-1:0] d_tmp;

    always begin
        @(negedge Sys_clk);
        #1;
        if (bus.RSARB_en && rs_pend.size() > 0)   d_tmp = rs_pend.pop_front();
        if (bus.LSBARB_en && lsb_pend.size() > 0) d_tmp = lsb_pend.pop_front();
        if (rs_pend.size() > 0 && bus.ARBRS_ready) begin
            bus.RSARB_en = 1'b1;
            {bus.RSARB_RoB_index, bus.RSARB_value, bus.RSARB_next_pc} = rs_pend[0];
        end else begin
            bus.RSARB_en = 1'b0;
            bus.RSARB_RoB_index = '0; bus.RSARB_value = '0; bus.RSARB_next_pc = '0;
        end
        if (lsb_pend.size() > 0 && bus.ARBLSB_ready) begin
            bus.LSBARB_en = 1'b1;
            d_tmp = lsb_pend[0];
            {bus.LSBARB_RoB_index, bus.LSBARB_value} = d_tmp[PW-1:AW];
        end else begin
            bus.LSBARB_en = 1'b0;
            bus.LSBARB_RoB_index = '0; bus.LSBARB_value = '0;
        end
    end

    task automatic step();
        @(posedge Sys_clk);
        #2;
    endtask

    function automatic logic [PW-1:0] mk(input int idx, input logic [31:0] v, input logic [AW-1:0] pc);
        return {RW'(idx), v, pc};
    endfunction

    // ---------------- directed + random sequence ----------------
    int          mark;
    logic [4:0]  e;
    logic [3:0]  lsb_seen[$];
    logic [4:0]  exp_order[6];
`ifdef CDB_ARB_STATS_EN
    logic [31:0] conf0;
`endif

    initial begin
        exp_order = '{5'h01, 5'h19, 5'h02, 5'h1A, 5'h03, 5'h1B};

        // reset
        step(); step();
        check("reset_cdb_en", bus.CDB_en, 1'b0);
        check("reset_cdb_idx", bus.CDB_RoB_index, 4'd0);
        Sys_rst_n = 1'b1;
        step();
        check("post_reset_rs_ready", bus.ARBRS_ready, 1'b1);
        check("post_reset_lsb_ready", bus.ARBLSB_ready, 1'b1);

        // single RS push: broadcast after the second edge, for one cycle
        rs_pend.push_back(mk(3, 32'h11, 32'h100));
        step(); step();
        check("single_en", bus.CDB_en, 1'b1);
        check("single_idx", bus.CDB_RoB_index, 4'd3);
        check("single_value", bus.CDB_value, 32'h11);
        check("single_pc", bus.CDB_next_pc, 32'h100);
        check("single_src", bus.CDB_src, 1'b0);
        step();
        check("single_one_cycle", bus.CDB_en, 1'b0);

        // simultaneous streams alternate starting with RS
        pre_judge = 1'b0; step(); pre_judge = 1'b1;
        mark = cdb_log.size();
`ifdef CDB_ARB_STATS_EN
        conf0 = stat_conf;
`endif
        for (int i = 1; i <= 3; i++) begin
            rs_pend.push_back(mk(i, 32'(i * 16), 32'(i * 4)));
            lsb_pend.push_back(mk(i + 8, 32'(i * 256), 32'h0));
        end
        repeat (8) step();
        check("rr_count", cdb_log.size() - mark, 6);
        for (int i = 0; i < 6; i++) begin
            e = (mark + i < cdb_log.size()) ? cdb_log[mark + i] : 5'h1F;
            check("rr_order", e, exp_order[i]);
        end
`ifdef CDB_ARB_STATS_EN
        check("rr_conflicts", stat_conf - conf0, 32'd5);
`endif

        // LSB back-pressure against a busy RS stream
        pre_judge = 1'b0; step(); pre_judge = 1'b1;
        mark = cdb_log.size();
        for (int i = 5; i <= 7; i++) lsb_pend.push_back(mk(i, 32'(i), 32'h0));
        for (int i = 0; i < 8; i++)  rs_pend.push_back(mk(i, 32'(i + 100), 32'(i)));
        step();
        check("bp_lsb_ready_1", bus.ARBLSB_ready, 1'b1);
        step();
        check("bp_lsb_ready_0", bus.ARBLSB_ready, 1'b0);
        repeat (14) step();
        lsb_seen.delete();
        for (int i = mark; i < cdb_log.size(); i++) begin
            e = cdb_log[i];
            if (e[4]) lsb_seen.push_back(e[3:0]);
        end
        check("bp_lsb_count", lsb_seen.size(), 3);
        for (int i = 0; i < 3; i++)
            check("bp_lsb_order", (i < lsb_seen.size()) ? lsb_seen[i] : 4'hF, 4'(i + 5));

        // flush with full queues and a same-cycle RS push
        for (int i = 0; i < 6; i++) begin
            rs_pend.push_back(mk(i, 32'(i + 200), 32'(i + 8)));
            lsb_pend.push_back(mk(i + 8, 32'(i + 300), 32'h0));
        end
        step(); step(); step();
        pre_judge = 1'b0;
        step();
        pre_judge = 1'b1;
        rs_pend.delete();
        lsb_pend.delete();
        mark = cdb_log.size();
        check("flush_rs_ready", bus.ARBRS_ready, 1'b1);
        check("flush_lsb_ready", bus.ARBLSB_ready, 1'b1);
        check("flush_en", bus.CDB_en, 1'b0);
        repeat (3) step();
        check("flush_no_bcast", cdb_log.size() - mark, 0);

        // Sys_rdy hold
        rs_pend.push_back(mk(4, 32'h44, 32'h440));
        step();
        Sys_rdy = 1'b0;
        repeat (4) begin
            step();
            check("hold_no_bcast", bus.CDB_en, 1'b0);
        end
        Sys_rdy = 1'b1;
        step();
        check("hold_release_en", bus.CDB_en, 1'b1);
        check("hold_release_idx", bus.CDB_RoB_index, 4'd4);
        step();
        check("hold_once", bus.CDB_en, 1'b0);

        // asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) begin
            rs_pend.push_back(mk(i, 32'(i), 32'(i)));
            lsb_pend.push_back(mk(i + 8, 32'(i), 32'h0));
        end
        step(); step(); step();
        check("pre_reset_bcast", bus.CDB_en, 1'b1);
        #1 Sys_rst_n = 1'b0;
        #1 check("async_reset_en", bus.CDB_en, 1'b0);
        rs_pend.delete();
        lsb_pend.delete();
        step();
        Sys_rst_n = 1'b1;
        step();
        rs_pend.push_back(mk(12, 32'hC, 32'h30));
        lsb_pend.push_back(mk(13, 32'hD, 32'h0));
        step(); step();
        check("post_reset_tie_src", bus.CDB_src, 1'b0);
        check("post_reset_tie_idx", bus.CDB_RoB_index, 4'd12);
        step();
        check("post_reset_second_src", bus.CDB_src, 1'b1);
        check("post_reset_second_idx", bus.CDB_RoB_index, 4'd13);

        // randomized traffic with holds and flushes
        repeat (400) begin
            step();
            Sys_rdy   = ($urandom_range(0, 9) != 0);
            pre_judge = ($urandom_range(0, 19) != 0);
            if (rs_pend.size() < 3 && $urandom_range(0, 1) == 1)
                rs_pend.push_back({4'($urandom_range(0, 15)), 32'($urandom), 32'($urandom)});
            if (lsb_pend.size() < 3 && $urandom_range(0, 1) == 1)
                lsb_pend.push_back({4'($urandom_range(0, 15)), 32'($urandom), 32'h0});
        end
        Sys_rdy = 1'b1;
        pre_judge = 1'b1;
        repeat (12) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
